cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
Memory-side responder for the single-cycle RISC-V core. One word array serves both the instruction-fetch port and the data load/store port.
- After reset, a byte-stream loader FSM fills the array from address 0 while the core is held in reset through cpu_rst.
- Once loading ends, the block serves combinational reads and synchronous stores for the core.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
ADDR_W, 10, log2(DEPTH_WORDS); word-index width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
inst_mem_addr  input  32  byte address of instruction fetch
inst_mem_read  output  32  fetched instruction word
data_mem_addr  input  32  byte address of load/store
data_mem_write  input  32  store data
mem_write  input  1  store enable
data_mem_read  output  32  load data
load_valid  input  1  loader byte valid
load_byte  input  8  loader byte
load_last  input  1  qualifies final byte of image (sampled with load_valid)
load_ready  output  1  loader may transfer a byte this cycle
cpu_rst  output  1  reset to core; high while loading
load_overflow  output  1  sticky: image exceeded DEPTH_WORDS
loaded_words  output  ADDR_W+1  words committed by loader

Behaviour:
- Addressing:
  - Word index = addr[ADDR_W+1:2]. addr[1:0] is ignored (word-aligned access only).
  - Any address with addr[31:ADDR_W+2] != 0 is out of range: reads return 32'h0, stores are dropped.
- Reads:
  - Both read ports are combinational from the array, zero cycles latency.
  - Read of a word being stored in the same cycle returns the old value; the new value is visible after the edge.
- FSM states: LOAD, RUN.
- rst=1 (at any time, including mid-load or mid-run):
  - Next state LOAD; byte counter=0, word pointer=0, assembly register=0, load_overflow=0, loaded_words=0.
  - Array contents are not cleared.
- LOAD state:
  - load_ready=1, cpu_rst=1. Core stores (mem_write) are ignored.
  - A transfer occurs when load_valid & load_ready.
  - Bytes are packed little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
  - On the 4th byte, the full word is written at the word pointer on that edge; pointer and loaded_words increment by 1; byte counter wraps to 0.
  - Transfer with load_last=1: the word (partial words zero-padded in unfilled upper bytes) is written and counted; state -> RUN at that edge.
  - load_last with load_valid=0 has no effect.
  - Pointer reaching DEPTH_WORDS:
    - Further completed words are not written and not counted.
    - load_overflow is set to 1 and stays set until rst.
    - Bytes are still accepted until load_last.
- RUN state:
  - load_ready=0, cpu_rst=0 (from the first cycle after the load_last transfer). Loader inputs are ignored.
  - Store: at a rising edge with mem_write=1 and an in-range address, array[index] <= data_mem_write.
  - RUN persists until rst.
- Outputs after reset: load_ready=1, cpu_rst=1, load_overflow=0, loaded_words=0. inst_mem_read and data_mem_read reflect the (uncleared) array.
- Simultaneous events: rst has priority over a loader transfer and over a store in the same cycle.

Test Plan:
1. rst 1 cycle, then stream bytes 13,05,00,00,93,00,10,00 with load_last on the last byte -> word0=32'h00000513, word1=32'h00100093; loaded_words=2; cpu_rst falls the cycle after the last byte; inst_mem_addr=4 gives 32'h00100093.
2. Stream 5 bytes AA,BB,CC,DD,EE with last on EE -> word0=32'hDDCCBBAA, word1=32'h000000EE, loaded_words=2.
3. In RUN, store data_mem_addr=8, data 32'hCAFEBABE, mem_write=1 -> data_mem_read at addr 8 shows the old value in the same cycle and CAFEBABE the next cycle; addr 11 also reads CAFEBABE; a store to 32'h0001_0000 changes nothing and reads 0.
4. DEPTH_WORDS=4, stream 24 bytes, last on 24th -> words 0-3 hold first 16 bytes, loaded_words=4, load_overflow=1.
5. rst asserted after 6 bytes mid-load, then a fresh 4-byte image -> word0 = the new image, loaded_words=1, no stale partial bytes. rst in RUN -> cpu_rst=1 and load_ready=1 the next cycle.
6. In LOAD, mem_write=1 at addr 0 concurrent with a loader transfer -> only the loader data is committed; load_valid pulses while in RUN leave the array unchanged.

Source files
------------

// File: rtl/cpu_mem_responder_if.sv
// Core/loader <-> memory responder bundle.
// master = core and loader side, slave = responder.
interface cpu_mem_responder_if #(
    parameter int ADDR_W = 10
);
    logic [31:0]     inst_mem_addr;
    logic [31:0]     inst_mem_read;
    logic [31:0]     data_mem_addr;
    logic [31:0]     data_mem_write;
    logic            mem_write;
    logic [31:0]     data_mem_read;
    logic            load_valid;
    logic [7:0]      load_byte;
    logic            load_last;
    logic            load_ready;
    logic            cpu_rst;
    logic            load_overflow;
    logic [ADDR_W:0] loaded_words;

    modport master (
        output inst_mem_addr, data_mem_addr, data_mem_write, mem_write,
        output load_valid, load_byte, load_last,
        input  inst_mem_read, data_mem_read, load_ready, cpu_rst,
        input  load_overflow, loaded_words
    );

    modport slave (
        input  inst_mem_addr, data_mem_addr, data_mem_write, mem_write,
        input  load_valid, load_byte, load_last,
        output inst_mem_read, data_mem_read, load_ready, cpu_rst,
        output load_overflow, loaded_words
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Shared instruction/data word array with a byte-stream boot loader
// that holds the core in reset until the image has been streamed in.
module cpu_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input logic clk,
    input logic rst,
    cpu_mem_responder_if.slave bus
);
    typedef enum logic {LOAD, RUN} state_e;

    state_e          state_q, state_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [ADDR_W:0] ptr_q, ptr_d;
    logic [23:0]     asm_q, asm_d;
    logic            ovf_q, ovf_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic              xfer;
    logic              commit;
    logic              full;
    logic [31:0]       word;
    logic              we;
    logic [ADDR_W-1:0] widx;
    logic [31:0]       wdat;
    logic              inst_ok;
    logic              data_ok;

    assign inst_ok = (bus.inst_mem_addr[31:ADDR_W+2] == '0);
    assign data_ok = (bus.data_mem_addr[31:ADDR_W+2] == '0);

    assign bus.inst_mem_read = inst_ok ?
        mem_q[bus.inst_mem_addr[ADDR_W+1:2]] : 32'h0;
    assign bus.data_mem_read = data_ok ?
        mem_q[bus.data_mem_addr[ADDR_W+1:2]] : 32'h0;

    assign bus.load_overflow = ovf_q;
    assign bus.loaded_words  = ptr_q;

    assign xfer   = bus.load_valid & bus.load_ready;
    assign commit = xfer & ((bcnt_q == 2'd3) | bus.load_last);
    // Pointer MSB set means every word of the array is already filled.
    assign full   = ptr_q[ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            bcnt_q  <= '0;
            ptr_q   <= '0;
            asm_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            ptr_q   <= ptr_d;
            asm_q   <= asm_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == LOAD && bus.load_valid && bus.load_last) begin
            state_d = RUN;
        end
    end

    always_comb begin
        bus.load_ready = (state_q == LOAD);
        bus.cpu_rst    = (state_q == LOAD);
    end

    // Little-endian packing; unfilled upper bytes read as zero.
    always_comb begin
        word = 32'h0;
        unique case (bcnt_q)
            2'd0: word = {24'h0, bus.load_byte};
            2'd1: word = {16'h0, bus.load_byte, asm_q[7:0]};
            2'd2: word = {8'h0, bus.load_byte, asm_q[15:0]};
            2'd3: word = {bus.load_byte, asm_q};
        endcase
    end

    always_comb begin
        bcnt_d = bcnt_q;
        ptr_d  = ptr_q;
        asm_d  = asm_q;
        ovf_d  = ovf_q;
        we     = 1'b0;
        widx   = ptr_q[ADDR_W-1:0];
        wdat   = word;
        if (xfer) begin
            bcnt_d = bcnt_q + 2'd1;
            asm_d  = word[23:0];
            if (commit) begin
                bcnt_d = '0;
                asm_d  = '0;
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    we    = 1'b1;
                    ptr_d = ptr_q + {{ADDR_W{1'b0}}, 1'b1};
                end
            end
        end else if (state_q == RUN && bus.mem_write && data_ok) begin
            we   = 1'b1;
            widx = bus.data_mem_addr[ADDR_W+1:2];
            wdat = bus.data_mem_write;
        end
        if (rst) begin
            we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdat;
        end
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: full-size and 4-word
// instances, directed loader/store sequences plus randomized runs.
module tb_cpu_mem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_mem_responder_if #(.ADDR_W(10)) ifm ();
    cpu_mem_responder_if #(.ADDR_W(2))  ifs ();

    cpu_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .bus(ifm)
    );
    cpu_mem_responder #(.DEPTH_WORDS(4), .ADDR_W(2)) dut_s (
        .clk(clk), .rst(rst), .bus(ifs)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mm [1024];
    bit          mv [1024];
    logic [31:0] sm_m [4];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] exp_same;
        logic [31:0] exp_next;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input bit s, input logic v, input logic [7:0] b,
                       input logic l);
        if (s) begin
            ifs.load_valid = v; ifs.load_byte = b; ifs.load_last = l;
        end else begin
            ifm.load_valid = v; ifm.load_byte = b; ifm.load_last = l;
        end
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_img(input bit s, input logic [7:0] q[$],
                            input bit gaps);
        for (int i = 0; i < q.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                drv(s, 1'b0, 8'($urandom), 1'b1);
                @(negedge clk);
            end
            drv(s, 1'b1, q[i], i == q.size() - 1);
            if (i == q.size() - 1) begin
                #1;
                chk("cpu_rst_loading", s ? ifs.cpu_rst : ifm.cpu_rst, 32'd1);
            end
            @(negedge clk);
        end
        drv(s, 1'b0, 8'h0, 1'b0);
        #1;
        chk("cpu_rst_run", s ? ifs.cpu_rst : ifm.cpu_rst, 32'd0);
        chk("load_ready_run", s ? ifs.load_ready : ifm.load_ready, 32'd0);
    endtask

    task automatic rd_chk(input bit s, input int idx,
                          input logic [31:0] exp, input string nm);
        logic [31:0] a;
        a = 32'(idx) << 2;
        @(negedge clk);
        if (s) begin
            ifs.inst_mem_addr = a;
            ifs.data_mem_addr = a | 32'($urandom_range(0, 3));
        end else begin
            ifm.inst_mem_addr = a;
            ifm.data_mem_addr = a | 32'($urandom_range(0, 3));
        end
        #1;
        chk({nm, "_inst"}, s ? ifs.inst_mem_read : ifm.inst_mem_read, exp);
        chk({nm, "_data"}, s ? ifs.data_mem_read : ifm.data_mem_read, exp);
    endtask

    // Image model: word i is bytes 4i..4i+3 little-endian, zero padded,
    // and only the first DEPTH words land in the array.
    task automatic expect_img(input bit s, input logic [7:0] q[$]);
        int depth;
        int nw;
        int nc;
        logic [31:0] w;
        depth = s ? 4 : 1024;
        nw = (q.size() + 3) / 4;
        nc = (nw < depth) ? nw : depth;
        for (int i = 0; i < nc; i++) begin
            w = '0;
            for (int k = 0; k < 4; k++)
                if (4 * i + k < q.size()) w[8*k +: 8] = q[4*i+k];
            if (s) sm_m[i] = w;
            else begin mm[i] = w; mv[i] = 1'b1; end
        end
        chk("loaded_words",
            s ? 32'(ifs.loaded_words) : 32'(ifm.loaded_words), 32'(nc));
        chk("load_overflow", s ? ifs.load_overflow : ifm.load_overflow,
            {31'b0, nw > depth});
        for (int i = 0; i < nc; i++)
            rd_chk(s, i, s ? sm_m[i] : mm[i], "img_word");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        vec_t tv[6];
        rst = 1'b1;
        ifm.inst_mem_addr = '0; ifm.data_mem_addr = '0;
        ifm.data_mem_write = '0; ifm.mem_write = 1'b0;
        ifs.inst_mem_addr = '0; ifs.data_mem_addr = '0;
        ifs.data_mem_write = '0; ifs.mem_write = 1'b0;
        drv(0, 0, 0, 0);
        drv(1, 0, 0, 0);
        do_rst();
        #1;
        chk("rst_load_ready", ifm.load_ready, 32'd1);
        chk("rst_cpu_rst", ifm.cpu_rst, 32'd1);
        chk("rst_overflow", ifm.load_overflow, 32'd0);
        chk("rst_loaded", 32'(ifm.loaded_words), 32'd0);
        chk("rst_s_loaded", 32'(ifs.loaded_words), 32'd0);

        // 1: two-word program
        q = {8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load_img(0, q, 0);
        expect_img(0, q);
        rd_chk(0, 0, 32'h00000513, "t1_w0");
        rd_chk(0, 1, 32'h00100093, "t1_w1");

        // 2: partial trailing word
        do_rst();
        q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        load_img(0, q, 0);
        expect_img(0, q);
        rd_chk(0, 0, 32'hDDCCBBAA, "t2_w0");
        rd_chk(0, 1, 32'h000000EE, "t2_w1");

        // 3: stores in RUN, table driven
        do_rst();
        q = {};
        for (int i = 0; i < 12; i++) q.push_back(8'(8'h10 + i));
        load_img(0, q, 0);
        expect_img(0, q);
        tv[0] = '{32'd8, 32'hCAFEBABE, 1'b1, 32'h1B1A1918, 32'hCAFEBABE};
        tv[1] = '{32'd11, 32'h0, 1'b0, 32'hCAFEBABE, 32'hCAFEBABE};
        tv[2] = '{32'h0001_0000, 32'h12345678, 1'b1, 32'h0, 32'h0};
        tv[3] = '{32'd2, 32'h0, 1'b0, 32'h13121110, 32'h13121110};
        tv[4] = '{32'd4, 32'h000000FF, 1'b1, 32'h17161514, 32'h000000FF};
        tv[5] = '{32'h0000_1000, 32'hDEADBEEF, 1'b1, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ifm.data_mem_addr = tv[i].addr;
            ifm.inst_mem_addr = tv[i].addr;
            ifm.data_mem_write = tv[i].wdata;
            ifm.mem_write = tv[i].we;
            #1;
            chk("t3_data_same", ifm.data_mem_read, tv[i].exp_same);
            chk("t3_inst_same", ifm.inst_mem_read, tv[i].exp_same);
            @(negedge clk);
            ifm.mem_write = 1'b0;
            #1;
            chk("t3_data_next", ifm.data_mem_read, tv[i].exp_next);
        end
        rd_chk(0, 0, 32'h13121110, "t3_w0_intact");

        // 4: overflow on the 4-word instance
        do_rst();
        q = {};
        for (int i = 0; i < 24; i++) q.push_back(8'(i + 1));
        load_img(1, q, 0);
        expect_img(1, q);
        rd_chk(1, 3, 32'h100F0E0D, "t4_w3");
        @(negedge clk);
        ifs.inst_mem_addr = 32'd16;
        #1;
        chk("t4_oor_read", ifs.inst_mem_read, 32'h0);

        // 5: reset mid-load, then reset in RUN
        do_rst();
        for (int i = 0; i < 6; i++) begin
            drv(0, 1'b1, 8'(8'h11 + i), 1'b0);
            @(negedge clk);
        end
        drv(0, 0, 0, 0);
        #1;
        chk("t5_mid_loaded", 32'(ifm.loaded_words), 32'd1);
        do_rst();
        #1;
        chk("t5_rst_loaded", 32'(ifm.loaded_words), 32'd0);
        q = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
        load_img(0, q, 0);
        expect_img(0, q);
        rd_chk(0, 0, 32'hA4A3A2A1, "t5_w0");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_run_rst_cpu", ifm.cpu_rst, 32'd1);
        chk("t5_run_rst_ready", ifm.load_ready, 32'd1);
        chk("t5_run_rst_loaded", 32'(ifm.loaded_words), 32'd0);

        // 6: core store during LOAD ignored; loader ignored in RUN
        do_rst();
        ifm.mem_write = 1'b1;
        ifm.data_mem_addr = 32'h0;
        ifm.data_mem_write = 32'hFFFFFFFF;
        q = {8'h01, 8'h02, 8'h03, 8'h04};
        load_img(0, q, 0);
        ifm.mem_write = 1'b0;
        expect_img(0, q);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drv(0, 1'b1, 8'($urandom), 1'($urandom));
        end
        @(negedge clk);
        drv(0, 0, 0, 0);
        rd_chk(0, 0, 32'h04030201, "t6_w0");
        chk("t6_loaded", 32'(ifm.loaded_words), 32'd1);

        // Randomized images and RUN traffic
        for (int it = 0; it < 6; it++) begin
            logic [31:0] a;
            logic [31:0] ia;
            logic [31:0] wd;
            int idx;
            int iidx;
            bit oor;
            bit ioor;
            bit we;
            int nl;
            for (int i = 0; i < 1024; i++) mv[i] = 1'b0;
            do_rst();
            q = {};
            nl = $urandom_range(1, 40);
            for (int i = 0; i < nl; i++) q.push_back(8'($urandom));
            load_img(0, q, 1);
            expect_img(0, q);
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                idx = $urandom_range(0, 15);
                oor = ($urandom_range(0, 4) == 0);
                a = {oor ? 20'($urandom_range(1, 255)) : 20'h0,
                     10'(idx), 2'($urandom)};
                iidx = $urandom_range(0, 15);
                ioor = ($urandom_range(0, 4) == 0);
                ia = {ioor ? 20'($urandom_range(1, 255)) : 20'h0,
                      10'(iidx), 2'($urandom)};
                we = 1'($urandom);
                wd = $urandom;
                ifm.data_mem_addr = a;
                ifm.inst_mem_addr = ia;
                ifm.data_mem_write = wd;
                ifm.mem_write = we;
                drv(0, 1'($urandom), 8'($urandom), 1'($urandom));
                #1;
                if (oor) chk("rnd_data_oor", ifm.data_mem_read, 32'h0);
                else if (mv[idx]) chk("rnd_data", ifm.data_mem_read, mm[idx]);
                if (ioor) chk("rnd_inst_oor", ifm.inst_mem_read, 32'h0);
                else if (mv[iidx]) chk("rnd_inst", ifm.inst_mem_read, mm[iidx]);
                if (we && !oor) begin
                    mm[idx] = wd;
                    mv[idx] = 1'b1;
                end
            end
            @(negedge clk);
            ifm.mem_write = 1'b0;
            drv(0, 0, 0, 0);
            #1;
            chk("rnd_loaded_stable", 32'(ifm.loaded_words),
                32'((q.size() + 3) / 4));
            for (int i = 0; i < 16; i++)
                if (mv[i]) rd_chk(0, i, mm[i], "rnd_final");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
